// File: rtl/reservation_station.sv
// Issue buffer ahead of dispatch: holds renamed ops, snoops the result broadcast, issues ready ops to idle FUs.
// Latency: a ready op dispatches on the edge after its allocation edge; the dispatch outputs are registered.
// Backpressure: alloc_ready drops when every entry is valid; alloc_valid is ignored while alloc_ready=0.
module reservation_station #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 7,
    parameter int EXEC_WIDTH = 4,
    parameter int RS_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          alloc_valid,
    output logic                          alloc_ready,
    input  logic [EXEC_WIDTH-1:0]         alloc_executionID,
    input  logic [TAG_WIDTH-1:0]          alloc_destTag,
    input  logic                          alloc_op1_ready,
    input  logic [DATA_WIDTH-1:0]         alloc_op1,
    input  logic [TAG_WIDTH-1:0]          alloc_op1_tag,
    input  logic                          alloc_op2_ready,
    input  logic [DATA_WIDTH-1:0]         alloc_op2,
    input  logic [TAG_WIDTH-1:0]          alloc_op2_tag,
    input  logic                          broadcastDataAvailable,
    input  logic [TAG_WIDTH-1:0]          broadcastDestinationTag,
    input  logic [DATA_WIDTH-1:0]         broadcastDestinationData,
    input  logic [(2**EXEC_WIDTH)-1:0]    availableFunctionalUnits,
    output logic                          dispatch,
    output logic [DATA_WIDTH-1:0]         op1,
    output logic [DATA_WIDTH-1:0]         op2,
    output logic [EXEC_WIDTH-1:0]         executionID,
    output logic [TAG_WIDTH-1:0]          executionTag,
    output logic [$clog2(RS_DEPTH):0]     occupancy
);

    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int OCC_W = IDX_W + 1;

    typedef struct packed {
        logic                  valid;
        logic [EXEC_WIDTH-1:0] exec_id;
        logic [TAG_WIDTH-1:0]  dest_tag;
        logic                  op1_ready;
        logic [DATA_WIDTH-1:0] op1_data;
        logic [TAG_WIDTH-1:0]  op1_tag;
        logic                  op2_ready;
        logic [DATA_WIDTH-1:0] op2_data;
        logic [TAG_WIDTH-1:0]  op2_tag;
    } entry_t;

    entry_t              rs_q [RS_DEPTH];
    entry_t              alloc_entry;
    logic                free_found;
    logic [IDX_W-1:0]    free_idx;
    logic                sel_found;
    logic [IDX_W-1:0]    sel_idx;
    logic [RS_DEPTH-1:0] cand;
    logic                alloc_fire;

    // Lowest-index free slot; scanning downward leaves the lowest hit last.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!rs_q[i].valid) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign alloc_ready = free_found;
    assign alloc_fire  = alloc_valid & free_found;

    // The FU that received last cycle's dispatch still reads idle, so it is masked for one cycle.
    always_comb begin
        cand = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            cand[i] = rs_q[i].valid & rs_q[i].op1_ready & rs_q[i].op2_ready
                    & availableFunctionalUnits[rs_q[i].exec_id]
                    & ~(dispatch && (rs_q[i].exec_id == executionID));
        end
    end

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // New entry image, including capture of a result broadcast on the allocation edge.
    always_comb begin
        alloc_entry           = '0;
        alloc_entry.valid     = 1'b1;
        alloc_entry.exec_id   = alloc_executionID;
        alloc_entry.dest_tag  = alloc_destTag;
        alloc_entry.op1_ready = alloc_op1_ready;
        alloc_entry.op1_data  = alloc_op1;
        alloc_entry.op1_tag   = alloc_op1_tag;
        alloc_entry.op2_ready = alloc_op2_ready;
        alloc_entry.op2_data  = alloc_op2;
        alloc_entry.op2_tag   = alloc_op2_tag;
        if (broadcastDataAvailable && !alloc_op1_ready
                && (alloc_op1_tag == broadcastDestinationTag)) begin
            alloc_entry.op1_ready = 1'b1;
            alloc_entry.op1_data  = broadcastDestinationData;
        end
        if (broadcastDataAvailable && !alloc_op2_ready
                && (alloc_op2_tag == broadcastDestinationTag)) begin
            alloc_entry.op2_ready = 1'b1;
            alloc_entry.op2_data  = broadcastDestinationData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                rs_q[i] <= '0;
            end
            dispatch     <= 1'b0;
            op1          <= '0;
            op2          <= '0;
            executionID  <= '0;
            executionTag <= '0;
            occupancy    <= '0;
        end else if (flush) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                rs_q[i].valid <= 1'b0;
            end
            dispatch  <= 1'b0;
            occupancy <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (rs_q[i].valid && broadcastDataAvailable) begin
                    if (!rs_q[i].op1_ready && (rs_q[i].op1_tag == broadcastDestinationTag)) begin
                        rs_q[i].op1_ready <= 1'b1;
                        rs_q[i].op1_data  <= broadcastDestinationData;
                    end
                    if (!rs_q[i].op2_ready && (rs_q[i].op2_tag == broadcastDestinationTag)) begin
                        rs_q[i].op2_ready <= 1'b1;
                        rs_q[i].op2_data  <= broadcastDestinationData;
                    end
                end
            end
            if (sel_found) begin
                rs_q[sel_idx].valid <= 1'b0;
                op1          <= rs_q[sel_idx].op1_data;
                op2          <= rs_q[sel_idx].op2_data;
                executionID  <= rs_q[sel_idx].exec_id;
                executionTag <= rs_q[sel_idx].dest_tag;
            end
            // The free slot was invalid before this edge, so it never collides with the issuing slot.
            if (alloc_fire) begin
                rs_q[free_idx] <= alloc_entry;
            end
            dispatch  <= sel_found;
            occupancy <= occupancy + OCC_W'(alloc_fire) - OCC_W'(sel_found);
        end
    end

endmodule
